// File: rtl/spi_wo_arb.sv
// Two-requester frame arbiter and byte sequencer in front of the spi_wo byte engine.
// Optional stall timeout is compiled in by defining SPI_ARB_TIMEOUT_EN.
module spi_wo_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic [7:0] data0_i,
  input  logic       last0_i,
  input  logic       req1_i,
  input  logic [7:0] data1_i,
  input  logic       last1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [1:0] gnt_o,
  output logic       abort_o,
  output logic [7:0] spi_data_o,
  output logic       spi_start_o,
  input  logic       spi_busy_i
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("spi_wo_arb: TIMEOUT must be within 1..65535");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       prio_q, prio_d;

  // Index of the current owner; only meaningful while gnt_q is non-zero.
  logic       wsel;
  logic       req_w;
  logic       last_w;
  logic [7:0] data_w;

  assign wsel   = gnt_q[1];
  assign req_w  = wsel ? req1_i  : req0_i;
  assign last_w = wsel ? last1_i : last0_i;
  assign data_w = wsel ? data1_i : data0_i;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = TIMEOUT[15:0];
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        stall_s;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    start_d = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (req0_i && req1_i) begin
          gnt_d   = prio_q ? 2'b10 : 2'b01;
          state_d = LOAD;
        end else if (req0_i || req1_i) begin
          gnt_d   = {req1_i, req0_i};
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Busy can still be high here after a reset abandoned a byte in flight.
        if (req_w && !spi_busy_i) begin
          data_d  = data_w;
          last_d  = last_w;
          start_d = 1'b1;
          ack0_d  = ~wsel;
          ack1_d  = wsel;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (spi_busy_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!spi_busy_i) begin
          if (last_q) begin
            gnt_d   = 2'b00;
            prio_d  = ~wsel;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    abort_d = 1'b0;
    stall_s = ((state_q == LOAD) && !req_w) || ((state_q == WAIT_HI) && !spi_busy_i);
    if (stall_s && (cnt_q == TO_LIM - 16'd1)) begin
      abort_d = 1'b1;
      gnt_d   = 2'b00;
      prio_d  = ~wsel;
      state_d = IDLE;
    end
    if (state_d != state_q) cnt_d = 16'd0;
    else if (stall_s)       cnt_d = cnt_q + 16'd1;
    else                    cnt_d = cnt_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      prio_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= 16'd0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      start_q <= start_d;
      data_q  <= data_d;
      last_q  <= last_d;
      prio_q  <= prio_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign spi_start_o = start_q;
  assign spi_data_o  = data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign abort_o     = abort_q;
`else
  assign abort_o     = 1'b0;
`endif

endmodule

// File: doc/spi_wo_arb.md
# spi_wo_arb

Two-requester arbiter and byte sequencer for the write-only SPI byte engine (`spi_wo`). It grants the engine to one requester at a time for a whole multi-byte frame, feeds bytes through the engine's `start_i`/`busy_o` handshake, and returns per-byte acknowledges. It sits between bus-side producers (for example display and DAC command writers) and the single `spi_wo` instance that drives the board SPI pins.

## Interface
Parameters:
- `TIMEOUT`, default 255 — stall limit in `clk_i` cycles; used only when `SPI_ARB_TIMEOUT_EN` is defined; legal range 1..65535.

Ports (`n` = 0, 1):
- `clk_i`  in  1  system clock; same clock as `spi_wo`.
- `rst_i`  in  1  synchronous, active-high reset.
- `reqn_i`  in  1  requester n has a valid byte on `datan_i`.
- `datan_i`  in  8  byte from requester n.
- `lastn_i`  in  1  the current byte ends requester n's frame.
- `ackn_o`  out  1  one-cycle pulse: requester n's current byte was captured.
- `gnt_o`  out  2  one-hot grant; bit n set while requester n owns the engine.
- `abort_o`  out  1  one-cycle pulse: frame dropped by timeout; constant 0 when the feature is compiled out.
- `spi_data_o`  out  8  byte to `spi_wo.data_i`.
- `spi_start_o`  out  1  one-cycle start pulse to `spi_wo.start_i`.
- `spi_busy_i`  in  1  from `spi_wo.busy_o`.

## Operation
- All outputs are registered. Reset values: `gnt_o`=00, `ack0_o`=`ack1_o`=0, `abort_o`=0, `spi_start_o`=0, `spi_data_o`=0x00.
- Reset also sets state to IDLE, the internal last flag to 0, the timeout counter to 0, and the round-robin pointer `prio` to 0, so requester 0 wins the first tie.
- State machine: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE
  - No request: stay in IDLE.
  - Exactly one request: grant that requester and go to LOAD.
  - Both requesting: grant requester `prio` and go to LOAD.
- LOAD (w = granted requester)
  - If `reqw_i`=1: capture `dataw_i` into `spi_data_o`, `lastw_i` into the last flag, pulse `spi_start_o` and `ackw_o`, go to WAIT_HI.
  - Otherwise: hold the grant and wait.
- WAIT_HI: wait for `spi_busy_i`=1, then go to WAIT_LO.
- WAIT_LO: wait for `spi_busy_i`=0.
  - Last flag = 1: clear `gnt_o`, set `prio` to the other requester, go to IDLE.
  - Last flag = 0: go back to LOAD.
- Grant is never preempted mid-frame. Requests from the other side are ignored until the frame ends.
- `spi_start_o` is only ever raised while `spi_busy_i`=0, so the engine never drops a start.
- A requester may change its data or `last` only after it sees `ackn_o`. The block samples each byte exactly once, in LOAD.
- Single-byte frame: `last`=1 on the first byte.

## Timing
- Request high at cycle N in IDLE: `gnt_o` set at N+1 (state LOAD). `spi_start_o`, `ackn_o`, and `spi_data_o` become valid at N+2 and are high for exactly one cycle.
- `spi_busy_i` is expected high by N+3, since the engine sets `busy` on the falling edge inside the start cycle.
- Back-to-back bytes: LOAD is re-entered one cycle after `busy` falls, and the next start is 2 cycles after `busy` falls, provided `req` is held.
- After the frame ends, `gnt_o` clears 1 cycle after `busy` falls. The next grant follows 1 cycle later at the earliest (IDLE is always visited once).
- `rst_i` mid-frame: all outputs return to reset values on the next edge and the byte in flight is abandoned. `spi_wo` finishes that byte on its own, but no new start is issued until IDLE → LOAD runs again and `busy` is low.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in LOAD while `reqw_i`=0, and in WAIT_HI while `spi_busy_i`=0.
  - It is cleared on every state change.
  - When it reaches `TIMEOUT`: pulse `abort_o`, clear `gnt_o`, advance `prio`, go to IDLE. Partial frames are discarded.
- `SPI_ARB_TIMEOUT_EN` undefined: no counter exists; LOAD and WAIT_HI wait indefinitely and `abort_o` is tied to 0.

## Test plan
- Reset, then `req0` with byte 0xA5 and `last`=1 → `gnt_o`=01 at N+1; `spi_start_o`/`ack0_o` for one cycle at N+2 with `spi_data_o`=0xA5; after `busy` falls, `gnt_o`=00.
- Requester 1 sends a 3-byte frame 0x11, 0x22, 0x33 (`last` on 0x33) while `req0` is asserted from the second byte onward → exactly 3 starts, each while `busy`=0, all with `gnt_o`=10; `gnt_o`=01 two cycles after the last `busy` fall.
- Both requesters continuously request 1-byte frames → grants alternate 01,10,01,10; the first grant goes to requester 0 after reset.
- `rst_i` pulsed during WAIT_LO of byte 2 of a 4-byte frame → next cycle `gnt_o`=00, no further start until a new request; a fresh frame afterwards transfers correctly.
- With `SPI_ARB_TIMEOUT_EN` and `TIMEOUT`=8, requester 0 drops `req` after byte 1 of a non-last frame → `abort_o` pulses after 8 stalled cycles, `gnt_o`=00, and a pending `req1` is granted next.
- Without the macro, the same stall → grant held indefinitely (checked for 1000 cycles), `abort_o` stays 0.
